// File: rtl/minmax_loader.sv
// Bus-master sequencer that loads the min/max engine's A registers from source memory,
// fires the engine, polls its trigger register and returns the min/max results.
module minmax_loader #(
    parameter logic [31:0] BASE     = 32'hC200_0000,
    parameter int          N_WORDS  = 8,
    parameter int          TIMEOUT  = 16,
    parameter int          POLL_MAX = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic [31:0] src_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] min_o,
    output logic [31:0] max_o,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        en,
    output logic        wr,
    output logic [31:0] waddr,
    output logic [31:0] din,
    output logic [31:0] raddr,
    input  logic [31:0] dout,
    input  logic        rready,
    input  logic        wready
);

    localparam int                TMR_W      = $clog2(TIMEOUT);
    localparam int                POLL_W     = $clog2(POLL_MAX + 32'sd1);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT - 32'sd1);
    localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(POLL_MAX);
    localparam logic [3:0]        IDX_LAST   = 4'(N_WORDS - 32'sd1);
    localparam logic [31:0]       MIN_ADDR   = BASE + 32'h0000_0020;
    localparam logic [31:0]       MAX_ADDR   = BASE + 32'h0000_0024;
    localparam logic [31:0]       TRIG_ADDR  = BASE + 32'h0000_0028;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_MRD   = 4'd1,
        S_MWAIT = 4'd2,
        S_WRA   = 4'd3,
        S_TRIG  = 4'd4,
        S_POLL  = 4'd5,
        S_RMIN  = 4'd6,
        S_RMAX  = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t              state_r;
    logic [3:0]          idx_r;
    logic [TMR_W-1:0]    tmr_r;
    logic [POLL_W-1:0]   poll_r;
    logic                pend_r;
    logic                ack_s;
    logic                tmo_s;
    logic [POLL_W-1:0]   poll_nxt_s;

    function automatic logic [31:0] word_off(input logic [3:0] idx);
        return {26'd0, idx, 2'b00};
    endfunction

    assign poll_nxt_s = poll_r + POLL_W'(1'b1);

    // Ready only counts while a request is outstanding; timeout fires on the last allowed cycle
    always_comb begin
        ack_s = 1'b0;
        tmo_s = 1'b0;
        if (pend_r) begin
            ack_s = wr ? wready : rready;
            tmo_s = !ack_s && (tmr_r == TMR_LAST);
        end else begin
            ack_s = 1'b0;
            tmo_s = 1'b0;
        end
    end

    // Sequencer: owns every registered output and all per-run state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= S_IDLE;
            idx_r    <= 4'd0;
            tmr_r    <= {TMR_W{1'b0}};
            poll_r   <= {POLL_W{1'b0}};
            pend_r   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            min_o    <= 32'd0;
            max_o    <= 32'd0;
            mem_en   <= 1'b0;
            mem_addr <= 32'd0;
            en       <= 1'b0;
            wr       <= 1'b0;
            waddr    <= 32'd0;
            din      <= 32'd0;
            raddr    <= 32'd0;
        end else begin
            en     <= 1'b0;
            mem_en <= 1'b0;
            done   <= 1'b0;
            if (pend_r) begin
                tmr_r <= tmr_r + TMR_W'(1'b1);
            end
            if (tmo_s) begin
                pend_r  <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                err     <= 1'b1;
                state_r <= S_DONE;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start) begin
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            min_o    <= 32'd0;
                            max_o    <= 32'd0;
                            idx_r    <= 4'd0;
                            mem_addr <= src_addr;
                            mem_en   <= 1'b1;
                            state_r  <= S_MRD;
                        end
                    end
                    S_MRD: begin
                        state_r <= S_MWAIT;
                    end
                    S_MWAIT: begin
                        din     <= mem_rdata;
                        waddr   <= BASE + word_off(idx_r);
                        wr      <= 1'b1;
                        en      <= 1'b1;
                        pend_r  <= 1'b1;
                        tmr_r   <= {TMR_W{1'b0}};
                        state_r <= S_WRA;
                    end
                    S_WRA: begin
                        if (ack_s) begin
                            idx_r <= idx_r + 4'd1;
                            if (idx_r == IDX_LAST) begin
                                waddr   <= TRIG_ADDR;
                                din     <= 32'd1;
                                en      <= 1'b1;
                                tmr_r   <= {TMR_W{1'b0}};
                                state_r <= S_TRIG;
                            end else begin
                                pend_r   <= 1'b0;
                                mem_addr <= mem_addr + 32'd4;
                                mem_en   <= 1'b1;
                                state_r  <= S_MRD;
                            end
                        end
                    end
                    S_TRIG: begin
                        if (ack_s) begin
                            poll_r  <= {POLL_W{1'b0}};
                            raddr   <= TRIG_ADDR;
                            wr      <= 1'b0;
                            en      <= 1'b1;
                            tmr_r   <= {TMR_W{1'b0}};
                            state_r <= S_POLL;
                        end
                    end
                    S_POLL: begin
                        if (ack_s) begin
                            poll_r <= poll_nxt_s;
                            if (dout == 32'd0) begin
                                raddr   <= MIN_ADDR;
                                en      <= 1'b1;
                                tmr_r   <= {TMR_W{1'b0}};
                                state_r <= S_RMIN;
                            end else if (poll_nxt_s == POLL_LIMIT) begin
                                pend_r  <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                err     <= 1'b1;
                                state_r <= S_DONE;
                            end else begin
                                // engine still busy: reissue the same read, restarting the timeout
                                en    <= 1'b1;
                                tmr_r <= {TMR_W{1'b0}};
                            end
                        end
                    end
                    S_RMIN: begin
                        if (ack_s) begin
                            min_o   <= dout;
                            raddr   <= MAX_ADDR;
                            en      <= 1'b1;
                            tmr_r   <= {TMR_W{1'b0}};
                            state_r <= S_RMAX;
                        end
                    end
                    S_RMAX: begin
                        if (ack_s) begin
                            max_o   <= dout;
                            pend_r  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            err     <= 1'b0;
                            state_r <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        err     <= 1'b0;
                        state_r <= S_IDLE;
                    end
                    default: begin
                        pend_r  <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_minmax_loader.sv
// Bench for minmax_loader: behavioural source memory and MMIO engine, randomized runs
// compared against expected transaction lists, results and timing.
module tb_minmax_loader;

    localparam logic [31:0] BASE = 32'hC200_0000;
    localparam int NW   = 8;
    localparam int TMO  = 16;
    localparam int PMAX = 64;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic        busy, done, err, mem_en, en, wr;
    logic [31:0] min_o, max_o, mem_addr, waddr, din, raddr;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] dout = 32'd0;
    logic        rready = 1'b0;
    logic        wready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    minmax_loader #(.BASE(BASE), .N_WORDS(NW), .TIMEOUT(TMO), .POLL_MAX(PMAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start(start), .src_addr(src_addr),
        .busy(busy), .done(done), .err(err), .min_o(min_o), .max_o(max_o),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .en(en), .wr(wr), .waddr(waddr), .din(din), .raddr(raddr),
        .dout(dout), .rready(rready), .wready(wready)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // source memory: word table, 1-cycle read latency, garbage when not enabled
    logic [31:0] mem_tbl [logic [31:0]];
    logic [31:0] sw [NW];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_tbl.exists(a)) return mem_tbl[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    always @(posedge clk_i) mem_rdata <= mem_en ? mem_word(mem_addr) : $urandom;

    // engine model: registers A, trig, min, max; acks ack_dly cycles after the en cycle
    bit          eng_on = 1'b1;
    int          ack_dly = 0;
    int          busy_polls = 0;
    logic [31:0] eng_a [NW];
    logic [31:0] eng_trig = 32'd0;
    logic [31:0] eng_min = 32'h1234_5678;
    logic [31:0] eng_max = 32'h8765_4321;
    int          polls_left = 0;
    bit          e_pend = 1'b0;
    int          e_cnt = 0;
    bit          e_wr = 1'b0;
    logic [31:0] e_addr = 32'd0;
    logic [31:0] e_din = 32'd0;

    always @(posedge clk_i) begin
        bit          fire;
        bit          fw;
        logic [31:0] fa;
        logic [31:0] fd;
        int          ai;
        fire = 1'b0; fw = 1'b0; fa = 32'd0; fd = 32'd0;
        wready <= 1'b0;
        rready <= 1'b0;
        dout   <= $urandom;
        if (rst_i) begin
            e_pend   = 1'b0;
            eng_trig = 32'd0;
        end else begin
            if (e_pend) begin
                if (e_cnt == 0) begin
                    fire = 1'b1; fw = e_wr; fa = e_addr; fd = e_din; e_pend = 1'b0;
                end else begin
                    e_cnt = e_cnt - 1;
                end
            end
            if (en && eng_on) begin
                if (ack_dly == 0) begin
                    fire = 1'b1; fw = wr; fa = wr ? waddr : raddr; fd = din;
                end else begin
                    e_pend = 1'b1; e_cnt = ack_dly - 1; e_wr = wr;
                    e_addr = wr ? waddr : raddr; e_din = din;
                end
            end
            if (fire && fw) begin
                wready <= 1'b1;
                ai = int'((fa - BASE) >> 2);
                if (fa == BASE + 32'h28) begin
                    eng_trig = fd; polls_left = busy_polls;
                end else if (ai >= 0 && ai < NW) begin
                    eng_a[ai] = fd;
                end
            end else if (fire) begin
                rready <= 1'b1;
                if (fa == BASE + 32'h28) begin
                    if (eng_trig != 32'd0) begin
                        if (polls_left > 0) polls_left = polls_left - 1;
                        else begin
                            eng_trig = 32'd0;
                            eng_min = eng_a[0]; eng_max = eng_a[0];
                            for (int k = 1; k < NW; k++) begin
                                if ($signed(eng_a[k]) < $signed(eng_min)) eng_min = eng_a[k];
                                if ($signed(eng_a[k]) > $signed(eng_max)) eng_max = eng_a[k];
                            end
                        end
                    end
                    dout <= eng_trig;
                end else if (fa == BASE + 32'h20) dout <= eng_min;
                else if (fa == BASE + 32'h24) dout <= eng_max;
                else dout <= 32'hBAD0_BAD0;
            end
        end
    end

    // transaction monitor, sampled on the falling edge
    logic [31:0] ma_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] ra_q[$];
    int en_cnt = 0;
    int done_cnt = 0;
    bit done_err = 1'b0;
    int done_cyc = 0;
    int first_en_cyc = -1;
    int start_cyc = 0;

    always @(negedge clk_i) begin
        if (mem_en) ma_q.push_back(mem_addr);
        if (en) begin
            en_cnt = en_cnt + 1;
            if (first_en_cyc < 0) first_en_cyc = cyc;
            if (wr) begin wa_q.push_back(waddr); wd_q.push_back(din); end
            else ra_q.push_back(raddr);
        end
        if (done) begin done_cnt = done_cnt + 1; done_err = err; done_cyc = cyc; end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        ma_q.delete(); wa_q.delete(); wd_q.delete(); ra_q.delete();
        en_cnt = 0; done_cnt = 0; done_err = 1'b0; first_en_cyc = -1;
    endtask

    task automatic load_src(input logic [31:0] src);
        for (int k = 0; k < NW; k++) mem_tbl[src + 32'(4 * k)] = sw[k];
    endtask

    task automatic pulse_start(input logic [31:0] src);
        tick();
        start = 1'b1; src_addr = src; start_cyc = cyc;
        tick();
        start = 1'b0; src_addr = $urandom;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin tick(); n++; end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s wait_done: no done within %0d cycles", tag, budget);
        end
    endtask

    // full successful run compared against the expected transaction lists and timing
    task automatic do_full_run(input logic [31:0] src, input int d, input int polls, input string tag);
        logic [31:0] emin, emax;
        int          exp_lat;
        bit          bad;
        ack_dly = d; busy_polls = polls; eng_on = 1'b1;
        load_src(src);
        clear_logs();
        pulse_start(src);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy); end
        wait_done(2000, tag);
        repeat (3) tick();
        emin = sw[0]; emax = sw[0];
        for (int k = 1; k < NW; k++) begin
            if ($signed(sw[k]) < $signed(emin)) emin = sw[k];
            if ($signed(sw[k]) > $signed(emax)) emax = sw[k];
        end
        checks++;
        if (done_cnt !== 1 || done_err !== 1'b0) begin
            errors++; $display("FAIL %s done: got count %0d err %b want count 1 err 0", tag, done_cnt, done_err);
        end
        bad = (ma_q.size() != NW);
        for (int k = 0; k < NW && !bad; k++) if (ma_q[k] !== src + 32'(4 * k)) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL %s mem_addr_seq: got %0d reads want %0d from %h", tag, ma_q.size(), NW, src); end
        bad = (wa_q.size() != NW + 1);
        for (int k = 0; k < NW && !bad; k++)
            if (wa_q[k] !== BASE + 32'(4 * k) || wd_q[k] !== sw[k]) bad = 1'b1;
        if (!bad && (wa_q[NW] !== BASE + 32'h28 || wd_q[NW] !== 32'd1)) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL %s write_seq: got %0d writes want %0d", tag, wa_q.size(), NW + 1); end
        bad = (ra_q.size() != polls + 3);
        for (int k = 0; k <= polls && !bad; k++) if (ra_q[k] !== BASE + 32'h28) bad = 1'b1;
        if (!bad && (ra_q[polls + 1] !== BASE + 32'h20 || ra_q[polls + 2] !== BASE + 32'h24)) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL %s read_seq: got %0d reads want %0d", tag, ra_q.size(), polls + 3); end
        checks++;
        if (min_o !== emin) begin errors++; $display("FAIL %s min_o: got %h want %h", tag, min_o, emin); end
        checks++;
        if (max_o !== emax) begin errors++; $display("FAIL %s max_o: got %h want %h", tag, max_o, emax); end
        exp_lat = NW * (4 + d) + (2 + d) * (polls + 4) + 1;
        checks++;
        if (done_cyc - start_cyc !== exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", tag, done_cyc - start_cyc, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, err, mem_en, en, wr} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000", {busy, done, err, mem_en, en, wr});
        end
        checks++;
        if ({min_o, max_o, mem_addr} !== 96'd0) begin
            errors++; $display("FAIL reset_data: got %h %h %h want zeros", min_o, max_o, mem_addr);
        end
        checks++;
        if ({waddr, din, raddr} !== 96'd0) begin
            errors++; $display("FAIL reset_bus: got %h %h %h want zeros", waddr, din, raddr);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        sw[0] = 32'd5;  sw[1] = 32'hFFFF_FFFD; sw[2] = 32'd7;          sw[3] = 32'd0;
        sw[4] = 32'd2;  sw[5] = 32'd9;         sw[6] = 32'hFFFF_FFF8;  sw[7] = 32'd1;
        do_full_run(32'h0000_0100, 0, 0, "basic");
        checks++;
        if (min_o !== 32'hFFFF_FFF8 || max_o !== 32'd9) begin
            errors++; $display("FAIL basic_result: got %h/%h want fffffff8/00000009", min_o, max_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] src;
        for (int r = 0; r < 4; r++) begin
            src = $urandom;
            src = src & 32'hFFFF_FFFC;
            for (int k = 0; k < NW; k++) sw[k] = $urandom;
            do_full_run(src, $urandom_range(0, 3), $urandom_range(0, 5), "random");
        end
    endtask

    task automatic test_poll_limit();
        for (int k = 0; k < NW; k++) sw[k] = $urandom;
        ack_dly = $urandom_range(0, 1); busy_polls = 1000;
        load_src(32'h0000_0300);
        clear_logs();
        pulse_start(32'h0000_0300);
        wait_done(2000, "poll_limit");
        repeat (3) tick();
        checks++;
        if (done_cnt !== 1 || done_err !== 1'b1) begin
            errors++; $display("FAIL poll_limit_done: got count %0d err %b want 1 1", done_cnt, done_err);
        end
        checks++;
        if (ra_q.size() !== PMAX) begin
            errors++; $display("FAIL poll_limit_reads: got %0d want %0d", ra_q.size(), PMAX);
        end
        checks++;
        if (min_o !== 32'd0 || max_o !== 32'd0) begin
            errors++; $display("FAIL poll_limit_results: got %h/%h want 0/0", min_o, max_o);
        end
    endtask

    task automatic test_write_timeout();
        eng_on = 1'b0; ack_dly = 0;
        clear_logs();
        pulse_start(32'h0000_0200);
        wait_done(200, "timeout");
        repeat (5) tick();
        checks++;
        if (done_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", done_err); end
        checks++;
        if (done_cyc - first_en_cyc !== TMO) begin
            errors++; $display("FAIL timeout_latency: got %0d want %0d", done_cyc - first_en_cyc, TMO);
        end
        checks++;
        if (en_cnt !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_quiet: got en %0d busy %b want 1 0", en_cnt, busy);
        end
        eng_on = 1'b1;
    endtask

    task automatic test_busy_start();
        bit bad;
        for (int k = 0; k < NW; k++) sw[k] = $urandom;
        load_src(32'h0000_0400);
        ack_dly = 1; busy_polls = 1;
        clear_logs();
        pulse_start(32'h0000_0400);
        repeat (6) tick();
        start = 1'b1; src_addr = 32'h0000_0800;
        tick();
        start = 1'b0;
        wait_done(2000, "busy_start");
        repeat (4) tick();
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done: got %0d want 1", done_cnt); end
        bad = (ma_q.size() != NW) || (wd_q.size() != NW + 1);
        for (int k = 0; k < NW && !bad; k++)
            if (ma_q[k] !== 32'h0000_0400 + 32'(4 * k) || wd_q[k] !== sw[k]) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL busy_start_addrs: got %0d reads want %0d from 00000400", ma_q.size(), NW); end
    endtask

    task automatic test_reset_in_poll();
        int n;
        int en_at_rst;
        for (int k = 0; k < NW; k++) sw[k] = $urandom;
        load_src(32'h0000_0500);
        ack_dly = 0; busy_polls = 1000;
        clear_logs();
        pulse_start(32'h0000_0500);
        n = 0;
        while (ra_q.size() < 3 && n < 300) begin tick(); n++; end
        checks++;
        if (ra_q.size() < 3) begin errors++; $display("FAIL rst_poll_reach: got %0d polls want 3", ra_q.size()); end
        rst_i = 1'b1;
        tick();
        checks++;
        if ({en, busy, done, mem_en} !== 4'b0 || min_o !== 32'd0 || max_o !== 32'd0) begin
            errors++; $display("FAIL rst_poll_outputs: got en %b busy %b done %b min %h max %h want zeros",
                               en, busy, done, min_o, max_o);
        end
        en_at_rst = en_cnt;
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (done_cnt !== 0 || en_cnt !== en_at_rst) begin
            errors++; $display("FAIL rst_poll_quiet: got done %0d en %0d want 0 %0d", done_cnt, en_cnt, en_at_rst);
        end
        for (int k = 0; k < NW; k++) sw[k] = $urandom;
        do_full_run(32'h0000_0600, 0, 2, "after_reset");
    endtask

    task automatic test_wrap();
        for (int k = 0; k < NW; k++) sw[k] = $urandom;
        do_full_run(32'hFFFF_FFFC, 0, 0, "wrap");
        checks++;
        if (ma_q.size() < 3 || ma_q[0] !== 32'hFFFF_FFFC || ma_q[1] !== 32'h0000_0000 || ma_q[2] !== 32'h0000_0004) begin
            errors++; $display("FAIL wrap_mem_addr: got %0d entries want fffffffc,00000000,00000004", ma_q.size());
        end
        checks++;
        if (wa_q.size() < 3 || wa_q[0] !== 32'hC200_0000 || wa_q[1] !== 32'hC200_0004 || wa_q[2] !== 32'hC200_0008) begin
            errors++; $display("FAIL wrap_waddr: got %0d entries want c2000000,c2000004,c2000008", wa_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_poll_limit();
        test_write_timeout();
        test_busy_start();
        test_reset_in_poll();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
